// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the keyboard clock and data,
// decodes 11-bit frames, folds E0/F0 prefixes into flags and queues scancodes in a
// first-word-fall-through FIFO.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DATA,
  input  logic                        CODE_READY,
  input  logic                        ERR_CLR,
  output logic                        CODE_VALID,
  output logic [7:0]                  CODE,
  output logic                        CODE_EXT,
  output logic                        CODE_BREAK,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
  output logic                        ERR_PARITY,
  output logic                        ERR_FRAME,
  output logic                        OVERFLOW
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic clk_meta_q, clk_sync_q;
  logic data_meta_q, data_sync_q;

  // Two-flop synchronisers; idle bus level is high, so reset to 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= PS2_CLK;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= PS2_DATA;
      data_sync_q <= data_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Clock deglitch filter
  // ---------------------------------------------------------------------------
  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall_evt;

  // Count consecutive samples that disagree with the filtered level; flip on the
  // FILTER_LEN-th one. A flip from 1 to 0 is the bit sample event.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_evt   = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d   = clk_sync_q;
        fall_evt = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_bad_q, par_bad_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           ext_q, ext_d;
  logic           brk_q, brk_d;
  logic           err_par_q, err_par_d;
  logic           err_frm_q, err_frm_d;
  logic           push;

  // Frame next-state: advances only on sample events; the watchdog aborts a stalled
  // frame but leaves the prefix flags alone so a retransmitted byte still pairs up.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    to_cnt_d  = to_cnt_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    err_par_d = 1'b0;
    err_frm_d = 1'b0;
    push      = 1'b0;
    if (fall_evt) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!data_sync_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
          end else begin
            err_frm_d = 1'b1;
          end
        end
        StData: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          // Odd parity: data bits plus parity bit must contain an odd number of ones.
          par_bad_d = ~(^shift_q ^ data_sync_q);
          state_d   = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!data_sync_q) begin
            err_frm_d = 1'b1;
          end else if (par_bad_q) begin
            err_par_d = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
        state_d   = StIdle;
        to_cnt_d  = '0;
        err_frm_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Frame decoder state register; error pulses are registered for clean outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      to_cnt_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      to_cnt_q  <= to_cnt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      err_par_q <= err_par_d;
      err_frm_q <= err_frm_d;
    end
  end

  assign ERR_PARITY = err_par_q;
  assign ERR_FRAME  = err_frm_q;

  // ---------------------------------------------------------------------------
  // Code FIFO
  // ---------------------------------------------------------------------------
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            pop, full, push_acc, ovf_set;

  // FIFO control: a pop frees the slot a same-cycle push needs, so a full FIFO
  // only drops when nothing is being read.
  always_comb begin
    pop      = (count_q != '0) && CODE_READY;
    full     = (count_q == CntW'(FIFO_DEPTH));
    push_acc = push && (!full || pop);
    ovf_set  = push && full && !pop;
    wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_acc && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_acc && pop) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ERR_CLR) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge CLK) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= {brk_q, ext_q, shift_q};
    end
  end

  assign CODE_VALID                    = (count_q != '0);
  assign {CODE_BREAK, CODE_EXT, CODE}  = mem_q[rd_ptr_q];
  assign FIFO_COUNT                    = count_q;
  assign OVERFLOW                      = ovf_q;

endmodule
